// File: rtl/conv_enc_stream.sv
// -----------------------------------------------------------------------------
// conv_enc_stream
//
// Rate-1/N feed-forward convolutional encoder with valid/ready handshakes on
// both sides and optional zero-tail frame termination. It sits between the
// bit source (scrambler/framer) and the modulator mapper.
//
// Parameters:
//   K        constraint length (>= 2); shift memory holds K-1 past bits
//   N        coded bits produced per info bit
//   GEN      N*K packed generators; GEN[j*K +: K] drives coded[j], and bit i
//            taps the input from i beats ago (bit 0 = current bit)
//   TAIL_EN  1: flush K-1 zero bits after in_last and flag the final tail beat
//            0: flag the in_last beat itself and clear the shift memory
//
// Ports:
//   clk        rising-edge clock
//   srst_n     asynchronous active-low reset
//   info       info bit
//   in_valid   info beat valid
//   in_last    last info bit of the frame (ignored while in_valid=0)
//   in_ready   encoder accepts an info beat this cycle
//   coded      N coded bits of the current output beat
//   out_valid  coded beat valid
//   out_last   last coded beat of the frame
//   out_ready  downstream accepts the coded beat
//   busy       high while flushing the tail or holding an output beat
// -----------------------------------------------------------------------------
module conv_enc_stream #(
  parameter int K       = 3,
  parameter int N       = 2,
  parameter     GEN     = {3'b101, 3'b111},
  parameter bit TAIL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         info,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] coded,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  // Elaboration-time parameter legality.
  if (K < 2 || N < 1 || $bits(GEN) != N * K) begin : g_bad_param
    $error("conv_enc_stream: need K >= 2, N >= 1 and GEN exactly N*K bits wide");
  end

  localparam logic [N*K-1:0] GEN_V = GEN;
  localparam int             CW    = $clog2(K);

  typedef enum logic {
    RUN,
    TAIL
  } state_t;

  state_t          state;
  logic [K-2:0]    sr;        // sr[0] = bit from 1 beat ago
  logic [CW-1:0]   tail_cnt;  // remaining tail beats
  logic [K-1:0]    w;         // encoding window, w[0] = current bit
  logic [N-1:0]    enc;
  logic            out_load;  // output register may take a new beat
  logic            accept;

  // During the tail the window is fed with zeros.
  assign w        = {sr, (state == TAIL) ? 1'b0 : info};
  assign out_load = !out_valid || out_ready;
  assign in_ready = (state == RUN) && out_load;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == TAIL) || out_valid;

  // NOTE: give every always_comb output a default before any branch or loop,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    enc = '0;
    for (int j = 0; j < N; j++) begin
      enc[j] = ^(GEN_V[j*K +: K] & w);
    end
  end

  // Shifting w[K-2:0] into sr pushes the current bit in at sr[0]; written this
  // way it stays legal for K=2 where sr is a single bit.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= RUN;
      sr        <= '0;
      tail_cnt  <= '0;
      coded     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // A transfer empties the output stage unless a new beat is loaded below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      unique case (state)
        RUN: begin
          if (accept) begin
            coded     <= enc;
            out_valid <= 1'b1;
            if (in_last && TAIL_EN) begin
              sr       <= w[K-2:0];
              tail_cnt <= CW'(K - 1);
              out_last <= 1'b0;
              state    <= TAIL;
            end else if (in_last) begin
              // Unterminated frame: the next frame restarts from the zero state.
              sr       <= '0;
              out_last <= 1'b1;
            end else begin
              sr       <= w[K-2:0];
              out_last <= 1'b0;
            end
          end
        end

        TAIL: begin
          if (out_load) begin
            coded     <= enc;
            out_valid <= 1'b1;
            sr        <= w[K-2:0];
            tail_cnt  <= tail_cnt - 1'b1;
            // After K-1 zero shifts sr is back at zero.
            if (tail_cnt == CW'(1)) begin
              out_last <= 1'b1;
              state    <= RUN;
            end else begin
              out_last <= 1'b0;
            end
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_stream.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_stream
//
// Directed bench for conv_enc_stream. Three instances share clk/srst_n:
//   a: defaults (K=3, N=2, GEN={101,111}, zero tail)
//   b: defaults with TAIL_EN=0
//   c: K=4, N=3, GEN={1011,1101,1111}
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_conv_enc_stream;

  logic clk = 1'b0;
  logic srst_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_info = 0, a_in_valid = 0, a_in_last = 0, a_out_ready = 1;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [1:0] a_coded;

  logic       b_info = 0, b_in_valid = 0, b_in_last = 0, b_out_ready = 1;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [1:0] b_coded;

  logic       c_info = 0, c_in_valid = 0, c_in_last = 0, c_out_ready = 1;
  logic       c_in_ready, c_out_valid, c_out_last, c_busy;
  logic [2:0] c_coded;

  int n_pass  = 0;
  int n_total = 0;

  conv_enc_stream dut_a (
    .clk(clk), .srst_n(srst_n),
    .info(a_info), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .coded(a_coded), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(a_out_ready), .busy(a_busy)
  );

  conv_enc_stream #(.TAIL_EN(1'b0)) dut_b (
    .clk(clk), .srst_n(srst_n),
    .info(b_info), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .coded(b_coded), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  conv_enc_stream #(.K(4), .N(3), .GEN({4'b1011, 4'b1101, 4'b1111})) dut_c (
    .clk(clk), .srst_n(srst_n),
    .info(c_info), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
    .coded(c_coded), .out_valid(c_out_valid), .out_last(c_out_last),
    .out_ready(c_out_ready), .busy(c_busy)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    srst_n = 1'b1;
    #1;
    n_total++; if ({a_coded, a_out_valid, a_out_last, a_busy, a_in_ready} !== 6'b000001)
      $display("FAIL reset_a: got %b required 000001", {a_coded, a_out_valid, a_out_last, a_busy, a_in_ready}); else n_pass++;
    n_total++; if ({b_coded, b_out_valid, b_out_last, b_busy, b_in_ready} !== 6'b000001)
      $display("FAIL reset_b: got %b required 000001", {b_coded, b_out_valid, b_out_last, b_busy, b_in_ready}); else n_pass++;
    n_total++; if ({c_coded, c_out_valid, c_out_last, c_busy, c_in_ready} !== 7'b0000001)
      $display("FAIL reset_c: got %b required 0000001", {c_coded, c_out_valid, c_out_last, c_busy, c_in_ready}); else n_pass++;
  endtask

  // Scenario 1: info 1,0,1,1 (last) with zero tail, downstream always ready.
  task automatic test_stream();
    logic [1:0] exp_c [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    logic [3:0] bits = 4'b1101;  // bits[i] is beat i
    a_out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_total++; if (a_out_valid !== 1'b1)
          $display("FAIL stream_valid[%0d]: got %b required 1", i-1, a_out_valid); else n_pass++;
        n_total++; if (a_coded !== exp_c[i-1])
          $display("FAIL stream_coded[%0d]: got %b required %b", i-1, a_coded, exp_c[i-1]); else n_pass++;
        n_total++; if (a_out_last !== (i == 6))
          $display("FAIL stream_last[%0d]: got %b required %b", i-1, a_out_last, (i == 6)); else n_pass++;
      end
      a_in_valid = (i < 4);
      a_info     = (i < 4) ? bits[i] : 1'b0;
      a_in_last  = (i == 3);
      #1;
      n_total++; if (a_in_ready !== (i < 4 || i == 6))
        $display("FAIL stream_in_ready[%0d]: got %b required %b", i, a_in_ready, (i < 4 || i == 6)); else n_pass++;
      n_total++; if (a_busy !== (i > 0))
        $display("FAIL stream_busy[%0d]: got %b required %b", i, a_busy, (i > 0)); else n_pass++;
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    @(negedge clk);
    n_total++; if ({a_out_valid, a_busy} !== 2'b00)
      $display("FAIL stream_drain: got %b required 00", {a_out_valid, a_busy}); else n_pass++;
  endtask

  // Scenario 2: stray in_last without valid, then impulse, then next frame.
  task automatic test_impulse();
    logic [1:0] exp_c [4] = '{2'b11, 2'b01, 2'b11, 2'b00};
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b1;
    @(negedge clk);
    n_total++; if ({a_in_ready, a_busy, a_out_valid} !== 3'b100)
      $display("FAIL stray_last_ignored: got %b required 100", {a_in_ready, a_busy, a_out_valid}); else n_pass++;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_total++; if ({a_out_valid, a_coded} !== {1'b1, exp_c[i-1]})
          $display("FAIL impulse_coded[%0d]: got %b required %b", i-1, {a_out_valid, a_coded}, {1'b1, exp_c[i-1]}); else n_pass++;
        n_total++; if (a_out_last !== (i == 3))
          $display("FAIL impulse_last[%0d]: got %b required %b", i-1, a_out_last, (i == 3)); else n_pass++;
      end
      a_in_valid = (i == 0 || i == 3);
      a_info     = (i == 0);
      a_in_last  = (i == 0);
      #1;
      if (i == 1 || i == 3) begin
        n_total++; if (a_in_ready !== (i == 3))
          $display("FAIL impulse_in_ready[%0d]: got %b required %b", i, a_in_ready, (i == 3)); else n_pass++;
      end
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    @(negedge clk);
  endtask

  // Scenario 3: stream 1 with out_ready low for 3 cycles after the first beat.
  task automatic test_backpressure();
    logic [1:0] exp_c [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    logic [3:0] bits = 4'b1101;
    int k = 0;
    int n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      @(negedge clk);
      a_out_ready = !(c >= 1 && c <= 3);
      #1;
      if (c >= 1 && c <= 3) begin
        n_total++; if ({a_out_valid, a_coded, a_out_last, a_in_ready} !== 5'b11100)
          $display("FAIL bp_stall[%0d]: got %b required 11100", c, {a_out_valid, a_coded, a_out_last, a_in_ready}); else n_pass++;
      end
      if (a_out_valid && a_out_ready) begin
        n_total++; if ({a_coded, a_out_last} !== {exp_c[n], n == 5})
          $display("FAIL bp_beat[%0d]: got %b required %b", n, {a_coded, a_out_last}, {exp_c[n], n == 5}); else n_pass++;
        n++;
      end
      a_in_valid = (k < 4);
      a_info     = (k < 4) ? bits[k[1:0]] : 1'b0;
      a_in_last  = (k == 3);
      if (a_in_valid && a_in_ready) k++;
    end
    a_in_valid  = 1'b0;
    a_in_last   = 1'b0;
    a_out_ready = 1'b1;
    n_total++; if (n !== 6)
      $display("FAIL bp_beat_count: got %0d required 6", n); else n_pass++;
    @(negedge clk);
  endtask

  // Scenario 4: no tail; info 1,1 (last) then a fresh 1.
  task automatic test_no_tail();
    logic [1:0] exp_c [3] = '{2'b11, 2'b10, 2'b11};
    b_out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0 && i < 4) begin
        n_total++; if ({b_out_valid, b_coded, b_out_last} !== {1'b1, exp_c[i-1], i == 2})
          $display("FAIL notail_beat[%0d]: got %b required %b", i-1, {b_out_valid, b_coded, b_out_last}, {1'b1, exp_c[i-1], i == 2}); else n_pass++;
      end
      if (i == 4) begin
        n_total++; if ({b_out_valid, b_busy} !== 2'b00)
          $display("FAIL notail_no_extra: got %b required 00", {b_out_valid, b_busy}); else n_pass++;
      end
      b_in_valid = (i < 3);
      b_info     = 1'b1;
      b_in_last  = (i == 1);
      #1;
      if (i == 2) begin
        n_total++; if (b_in_ready !== 1'b1)
          $display("FAIL notail_in_ready: got %b required 1", b_in_ready); else n_pass++;
      end
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Scenario 5: K=4, N=3 impulse.
  task automatic test_k4n3();
    logic [2:0] exp_c [4] = '{3'b111, 3'b101, 3'b011, 3'b111};
    c_out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_total++; if ({c_out_valid, c_coded, c_out_last} !== {1'b1, exp_c[i-1], i == 4})
          $display("FAIL k4n3_beat[%0d]: got %b required %b", i-1, {c_out_valid, c_coded, c_out_last}, {1'b1, exp_c[i-1], i == 4}); else n_pass++;
        n_total++; if (c_in_ready !== (i == 4))
          $display("FAIL k4n3_in_ready[%0d]: got %b required %b", i, c_in_ready, (i == 4)); else n_pass++;
      end
      c_in_valid = (i == 0);
      c_info     = 1'b1;
      c_in_last  = (i == 0);
    end
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
  endtask

  // Scenario 6: reset during the first tail cycle, then a fresh impulse.
  task automatic test_reset_mid_tail();
    logic [1:0] exp_c [3] = '{2'b11, 2'b01, 2'b11};
    logic [3:0] bits = 4'b1101;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_info     = bits[i];
      a_in_last  = (i == 3);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    #1;
    n_total++; if ({a_busy, a_in_ready} !== 2'b10)
      $display("FAIL midtail_in_tail: got %b required 10", {a_busy, a_in_ready}); else n_pass++;
    srst_n = 1'b0;
    #1;
    n_total++; if ({a_out_valid, a_out_last, a_coded, a_busy} !== 5'b00000)
      $display("FAIL midtail_reset: got %b required 00000", {a_out_valid, a_out_last, a_coded, a_busy}); else n_pass++;
    @(negedge clk);
    srst_n = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_total++; if ({a_out_valid, a_coded, a_out_last} !== {1'b1, exp_c[i-1], i == 3})
          $display("FAIL midtail_impulse[%0d]: got %b required %b", i-1, {a_out_valid, a_coded, a_out_last}, {1'b1, exp_c[i-1], i == 3}); else n_pass++;
      end
      a_in_valid = (i == 0);
      a_info     = 1'b1;
      a_in_last  = (i == 0);
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    srst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_impulse();
    test_backpressure();
    test_no_tail();
    test_k4n3();
    test_reset_mid_tail();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
